// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with per-digit dp, blank mask,
// leading-zero suppression and frame-synchronous (double-buffered) updates.
module seg7_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lzs_en,
  input  logic                  load,
  output logic [6:0]            eight_decode,
  output logic                  dp,
  output logic [DIGITS-1:0]     mie,
  output logic                  frame_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lzs;
  } frame_t;

  logic [DW-1:0]     r_div;
  logic [IW-1:0]     r_idx;
  frame_t            r_pend;
  frame_t            r_act;
  logic              r_pend_valid;

  logic              w_tc;
  logic              w_wrap;
  frame_t            w_load_frame;
  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_zrun;
  logic              w_dark;
  logic [6:0]        w_seg;
  logic              w_dp;
  logic [DIGITS-1:0] w_an;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h3F;  4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;  4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;  4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;  4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;  4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;  4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;  default: hex_to_seg = 7'h71;
    endcase
  endfunction

  assign w_tc         = (r_div == DIV_LAST);
  assign w_wrap       = w_tc && (r_idx == IDX_LAST);
  assign w_load_frame = {value, dp_in, blank_in, lzs_en};

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // load is a single-cycle strobe with no back-pressure: it always lands in
  // pending. Pending moves to active only at a wrap, so a frame never tears;
  // a load on the wrap cycle itself stays pending for one more frame.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_pend       <= '0;
      r_act        <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_wrap && r_pend_valid) r_act <= r_pend;
      if (load) begin
        r_pend       <= w_load_frame;
        r_pend_valid <= 1'b1;
      end else if (w_wrap) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // w_zrun[i] = nibble i and every nibble above it are zero.
  always_comb begin : p_zrun
    logic v_z;
    v_z    = 1'b1;
    w_zrun = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_z       = v_z & (r_act.value[4*i +: 4] == 4'h0);
      w_zrun[i] = v_z;
    end
  end

  always_comb begin
    w_an        = '0;
    w_an[r_idx] = 1'b1;
    w_nib       = r_act.value[{r_idx, 2'b00} +: 4];
    w_dark      = r_act.blank[r_idx] |
                  (r_act.lzs & (r_idx != '0) & w_zrun[r_idx]);
    w_seg       = w_dark ? 7'h00 : hex_to_seg(w_nib);
    w_dp        = r_act.dp[r_idx] & ~w_dark;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      eight_decode <= {7{SEG_INV}};
      dp           <= SEG_INV;
      mie          <= {DIGITS{AN_INV}};
      frame_done   <= 1'b0;
    end else begin
      eight_decode <= w_seg ^ {7{SEG_INV}};
      dp           <= w_dp ^ SEG_INV;
      mie          <= w_an ^ {DIGITS{AN_INV}};
      frame_done   <= w_wrap;
    end
  end

endmodule
